// File: rtl/sonar_wb_pkg.sv
// Shared types for the sonar Wishbone master.
// FSM states and the 69-bit queued command bundle.
package sonar_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbm_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } cmd_t;

endpackage

// File: rtl/sonar_cmd_fifo.sv
// First-word-fall-through command queue.
// Pointers carry one wrap bit to tell full from empty.
module sonar_cmd_fifo
  import sonar_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  cmd_t din_i,
  input  logic pop_i,
  output cmd_t dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_t        mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        do_push;
  logic        do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  // Pointer registers; reset empties the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage; contents are don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/sonar_wb_master.sv
// Queued Wishbone classic master with ack timeout.
// One bus cycle in flight; responses in command order.
module sonar_wb_master
  import sonar_wb_pkg::*;
#(
  parameter int TIMEOUT    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  wbm_state_t  state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;

  cmd_t fifo_din;
  cmd_t fifo_head;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;
  logic fifo_push;

  assign fifo_din  = '{we: cmd_we, adr: cmd_adr,
                       dat: cmd_dat, sel: cmd_sel};
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;

  sonar_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_i),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next state: issue, wait for ack or expiry, hold response.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_head;
          cnt_d    = '0;
          state_d  = BUS;
        end
      end
      BUS: begin
        cnt_d = cnt_q + 8'd1;
        if (wbm_ack_i) begin
          rsp_dat_d = cmd_q.we ? 32'd0 : wbm_dat_i;
          rsp_err_d = 1'b0;
          cnt_d     = '0;
          state_d   = RESP;
        end else if (cnt_q == TO_LAST) begin
          rsp_dat_d = 32'd0;
          rsp_err_d = 1'b1;
          cnt_d     = '0;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops the bus at once.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign wbm_cyc_o = (state_q == BUS);
  assign wbm_stb_o = (state_q == BUS);
  assign wbm_we_o  = cmd_q.we;
  assign wbm_adr_o = cmd_q.adr;
  assign wbm_dat_o = cmd_q.dat;
  assign wbm_sel_o = cmd_q.sel;
  assign rsp_valid = (state_q == RESP);
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sonar_wb_master.sv
// Directed bench for sonar_wb_master.
// Responder acks after a programmable stb count.
module tb_sonar_wb_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        ack = 1'b0;
  logic [31:0] rdat;

  int          checks = 0;
  int          errors = 0;
  bit          ack_en = 1'b1;
  int          ack_dly = 1;
  int          stb_cnt = 0;
  logic [31:0] key = '0;

  sonar_wb_master #(
    .TIMEOUT    (16),
    .FIFO_DEPTH (4)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (cyc),
    .wbm_stb_o (stb),
    .wbm_we_o  (we),
    .wbm_adr_o (adr),
    .wbm_dat_o (wdat),
    .wbm_sel_o (sel),
    .wbm_ack_i (ack),
    .wbm_dat_i (rdat)
  );

  always #5 clk = ~clk;

  assign rdat = adr ^ key;

  // Responder: ack in the ack_dly-th cycle of stb.
  always @(negedge clk) begin
    if (cyc && stb) begin
      stb_cnt = stb_cnt + 1;
      ack = ack_en && (stb_cnt == ack_dly);
    end else begin
      stb_cnt = 0;
      ack = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  task automatic send_cmd(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL send_cmd: cmd_ready stuck low adr=%h", a);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string nm);
    int n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: rsp_valid got %b want 1", nm, rsp_valid);
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({cyc, stb, we, rsp_valid, rsp_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 00000",
               {cyc, stb, we, rsp_valid, rsp_err});
    end
    checks++;
    if ({adr, wdat, sel, rsp_dat} !== 100'd0) begin
      errors++;
      $display("FAIL reset_data: adr=%h dat=%h sel=%h rsp=%h want 0",
               adr, wdat, sel, rsp_dat);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    ack_en = 1'b1; ack_dly = 2; key = 32'hDEAD_0000;
    send_cmd(1'b1, 32'h3000_0004, 32'h0000_0017, 4'hF);
    checks++;
    if (stb !== 1'b0) begin
      errors++;
      $display("FAIL wr_latency_early: stb got %b want 0", stb);
    end
    @(negedge clk);
    checks++;
    if ({cyc, stb, we} !== 3'b111) begin
      errors++;
      $display("FAIL wr_stb: cyc/stb/we got %b want 111", {cyc, stb, we});
    end
    checks++;
    if ({adr, wdat, sel} !== {32'h3000_0004, 32'h0000_0017, 4'hF}) begin
      errors++;
      $display("FAIL wr_bus: adr=%h dat=%h sel=%h want 30000004 00000017 f",
               adr, wdat, sel);
    end
    wait_rsp("wr_rsp");
    checks++;
    if ({rsp_dat, rsp_err, cyc} !== {32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wr_rsp_val: dat=%h err=%b cyc=%b want 0 0 0",
               rsp_dat, rsp_err, cyc);
    end
    consume();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_rsp_clear: rsp_valid got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_read();
    ack_en = 1'b1; ack_dly = 1; key = 32'hCFFF_FE30;
    send_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    wait_rsp("rd_rsp");
    checks++;
    if ({rsp_dat, rsp_err} !== {32'hFFFF_FE38, 1'b0}) begin
      errors++;
      $display("FAIL rd_data: dat=%h err=%b want fffffe38 0",
               rsp_dat, rsp_err);
    end
    consume();
  endtask

  task automatic test_timeout();
    int hi = 0;
    ack_en = 1'b0; key = 32'h0;
    send_cmd(1'b0, 32'h3000_000C, 32'h0, 4'hF);
    @(negedge clk);
    while (stb && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    checks++;
    if (hi != 16) begin
      errors++;
      $display("FAIL to_len: stb high %0d cycles want 16", hi);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL to_rsp: valid=%b err=%b dat=%h want 1 1 0",
               rsp_valid, rsp_err, rsp_dat);
    end
    consume();
    ack_en = 1'b1; ack_dly = 16;
    send_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    wait_rsp("to_edge_rsp");
    checks++;
    if ({rsp_err, rsp_dat} !== {1'b0, 32'h3000_0010}) begin
      errors++;
      $display("FAIL to_edge_ack: err=%b dat=%h want 0 30000010",
               rsp_err, rsp_dat);
    end
    consume();
  endtask

  task automatic test_full();
    ack_en = 1'b1; ack_dly = 12; key = 32'h5A5A_0000;
    for (int i = 0; i < 4; i++)
      send_cmd(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'h3);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pre: cmd_ready got %b want 1", cmd_ready);
    end
    send_cmd(1'b0, 32'h110, 32'h0, 4'h3);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_flag: cmd_ready got %b want 0", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: cmd_ready got %b want 0", cmd_ready);
    end
    for (int i = 0; i < 5; i++) begin
      wait_rsp("full_rsp");
      checks++;
      if (rsp_dat !== ((32'h100 + 32'(i * 4)) ^ 32'h5A5A_0000)) begin
        errors++;
        $display("FAIL full_order[%0d]: dat=%h want %h", i, rsp_dat,
                 (32'h100 + 32'(i * 4)) ^ 32'h5A5A_0000);
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    ack_en = 1'b1; ack_dly = 1; key = 32'h0;
    send_cmd(1'b0, 32'h200, 32'h0, 4'hF);
    send_cmd(1'b0, 32'h204, 32'h0, 4'hF);
    wait_rsp("bp_rsp_a");
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rsp_valid, rsp_dat, stb} !== {1'b1, 32'h200, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b dat=%h stb=%b want 1 200 0",
                 i, rsp_valid, rsp_dat, stb);
      end
      @(negedge clk);
    end
    consume();
    checks++;
    if ({rsp_valid, stb} !== 2'b00) begin
      errors++;
      $display("FAIL bp_gap: valid=%b stb=%b want 00", rsp_valid, stb);
    end
    @(negedge clk);
    checks++;
    if ({stb, adr} !== {1'b1, 32'h204}) begin
      errors++;
      $display("FAIL bp_next: stb=%b adr=%h want 1 204", stb, adr);
    end
    wait_rsp("bp_rsp_b");
    checks++;
    if (rsp_dat !== 32'h204) begin
      errors++;
      $display("FAIL bp_b_data: dat=%h want 204", rsp_dat);
    end
    consume();
  endtask

  task automatic test_reset_mid_bus();
    int bad = 0;
    ack_en = 1'b0;
    send_cmd(1'b1, 32'h300, 32'h1, 4'hF);
    send_cmd(1'b1, 32'h304, 32'h2, 4'hF);
    send_cmd(1'b1, 32'h308, 32'h3, 4'hF);
    checks++;
    if (stb !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: stb got %b want 1", stb);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cyc, stb, rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rst_async: cyc/stb/valid got %b want 000",
               {cyc, stb, rsp_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cyc || stb || rsp_valid || !cmd_ready) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_quiet: %0d active cycles want 0", bad);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_write();
    test_read();
    test_timeout();
    test_full();
    test_back_to_back();
    test_reset_mid_bus();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
